// File: rtl/lab1_operand_feeder.sv
// lab1_operand_feeder
//
// Purpose:
//   Front end for the LAB1 combinational evaluator. Collects a frame of six
//   serial 4-bit operands (plus a 3-bit rule taken with the first nibble),
//   presents them to LAB1 on registered, stable buses, waits SETTLE_CYCLES
//   cycles for LAB1 to settle, then captures LAB1's signed 10-bit result and
//   returns it with a one-cycle valid pulse. A gap inside a frame aborts it.
//
// Parameters:
//   SETTLE_CYCLES  cycles the operands are held before lab_out is sampled
//                  (legal 1..7)
//
// Ports:
//   clk           clock, rising-edge active
//   rst_n         asynchronous active-low reset
//   in_valid      nibble on in_data is valid this cycle
//   in_data       serial operand nibble (first -> op_0, sixth -> op_5)
//   in_rule_s     rule, sampled only with the first nibble of a frame
//   in_ready      feeder accepts a nibble this cycle
//   op_0..op_5    registered operand buses to LAB1 in_0..in_5
//   op_rule       registered rule to LAB1 in_rule
//   lab_out       signed result from LAB1
//   out_valid     one-cycle pulse, out is valid
//   out           captured result, 0 whenever out_valid is low
//   err           one-cycle pulse, frame aborted
module lab1_operand_feeder #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic [2:0] in_rule_s,
  output logic       in_ready,
  output logic [3:0] op_0,
  output logic [3:0] op_1,
  output logic [3:0] op_2,
  output logic [3:0] op_3,
  output logic [3:0] op_4,
  output logic [3:0] op_5,
  output logic [2:0] op_rule,
  input  logic [9:0] lab_out,
  output logic       out_valid,
  output logic [9:0] out,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SETTLE,
    ST_OUTPUT
  } state_t;

  // Settle counter counts down to zero; the capture happens on the edge that
  // ends the cycle in which it reads zero, giving exactly SETTLE_CYCLES cycles.
  localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [2:0] r_settle;
  logic [3:0] r_op [6];
  logic [2:0] r_rule;
  logic [9:0] r_out;
  logic       r_out_valid;
  logic       r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_settle    <= 3'd0;
      r_rule      <= 3'd0;
      r_out       <= 10'd0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        r_op[i] <= 4'd0;
      end
    end else begin
      // err is a single-cycle pulse; only the abort path raises it.
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op[0] <= in_data;
            r_rule  <= in_rule_s;
            r_cnt   <= 3'd1;
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (in_valid) begin
            r_op[r_cnt] <= in_data;
            if (r_cnt == 3'd5) begin
              r_cnt    <= 3'd0;
              r_settle <= SETTLE_LOAD;
              r_state  <= ST_SETTLE;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end else begin
            // Frames must be contiguous: a gap discards the partial frame.
            for (int i = 0; i < 6; i++) begin
              r_op[i] <= 4'd0;
            end
            r_rule  <= 3'd0;
            r_cnt   <= 3'd0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (r_settle == 3'd0) begin
            r_out       <= lab_out;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUTPUT;
          end else begin
            r_settle <= r_settle - 3'd1;
          end
        end
        ST_OUTPUT: begin
          // Operand buses intentionally keep the last frame until the next one.
          r_out       <= 10'd0;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
  assign op_0      = r_op[0];
  assign op_1      = r_op[1];
  assign op_2      = r_op[2];
  assign op_3      = r_op[3];
  assign op_4      = r_op[4];
  assign op_5      = r_op[5];
  assign op_rule   = r_rule;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_lab1_operand_feeder.sv
module tb_lab1_operand_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit 1: SETTLE_CYCLES=1, unit 3: SETTLE_CYCLES=3
  logic       rst_n1, iv1, rdy1, ov1, err1;
  logic [3:0] id1;
  logic [2:0] ir1, rule1;
  logic [3:0] op1 [6];
  logic [9:0] lab1, out1;

  logic       rst_n3, iv3, rdy3, ov3, err3;
  logic [3:0] id3;
  logic [2:0] ir3, rule3;
  logic [3:0] op3 [6];
  logic [9:0] lab3, out3;

  lab1_operand_feeder #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n1), .in_valid(iv1), .in_data(id1), .in_rule_s(ir1),
    .in_ready(rdy1), .op_0(op1[0]), .op_1(op1[1]), .op_2(op1[2]), .op_3(op1[3]),
    .op_4(op1[4]), .op_5(op1[5]), .op_rule(rule1), .lab_out(lab1),
    .out_valid(ov1), .out(out1), .err(err1)
  );

  lab1_operand_feeder #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n3), .in_valid(iv3), .in_data(id3), .in_rule_s(ir3),
    .in_ready(rdy3), .op_0(op3[0]), .op_1(op3[1]), .op_2(op3[2]), .op_3(op3[3]),
    .op_4(op3[4]), .op_5(op3[5]), .op_rule(rule3), .lab_out(lab3),
    .out_valid(ov3), .out(out3), .err(err3)
  );

  typedef struct {
    logic [9:0] val;
    int         cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt1 = 0;
  int err_cnt3 = 0;

  logic [3:0] nb [6];
  logic [2:0] rl [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitors / scoreboard consumers
  always @(negedge clk) begin
    if (ov1) begin
      if (q1.size() == 0) begin
        check("u1_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("u1_out", 32'(out1), 32'(e.val));
        check("u1_latency", 32'(cyc), 32'(e.cyc));
        $display("u1 result out=0x%0h cycle=%0d", out1, cyc);
      end
    end else if (out1 != 10'd0) begin
      check("u1_out_zero_when_idle", 32'(out1), 32'd0);
    end
    if (err1) err_cnt1++;
    if (err1 && ov1) check("u1_err_and_valid", 32'd1, 32'd0);
  end

  always @(negedge clk) begin
    if (ov3) begin
      if (q3.size() == 0) begin
        check("u3_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("u3_out", 32'(out3), 32'(e.val));
        check("u3_latency", 32'(cyc), 32'(e.cyc));
        $display("u3 result out=0x%0h cycle=%0d", out3, cyc);
      end
    end else if (out3 != 10'd0) begin
      check("u3_out_zero_when_idle", 32'(out3), 32'd0);
    end
    if (err3) err_cnt3++;
    if (err3 && ov3) check("u3_err_and_valid", 32'd1, 32'd0);
  end

  function automatic logic [3:0] get_op(input int d, input int i);
    return (d == 1) ? op1[i] : op3[i];
  endfunction

  function automatic logic [2:0] get_rule(input int d);
    return (d == 1) ? rule1 : rule3;
  endfunction

  function automatic logic get_rdy(input int d);
    return (d == 1) ? rdy1 : rdy3;
  endfunction

  task automatic drive(input int d, input logic v, input logic [3:0] dat, input logic [2:0] r);
    if (d == 1) begin
      iv1 = v; id1 = dat; ir1 = r;
    end else begin
      iv3 = v; id3 = dat; ir3 = r;
    end
  endtask

  // Sends nb/rl as one frame; returns in cycle T+1 with in_valid low.
  task automatic send_frame(input int d, input logic [9:0] lab, input logic [9:0] expv,
                            output int t_first, output int t_last);
    int   guard;
    int   s;
    exp_t e;
    guard = 0;
    s = (d == 1) ? 1 : 3;
    @(negedge clk);
    while (!get_rdy(d) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("u%0d_ready_at_frame_start", d), 32'(get_rdy(d)), 32'd1);
    if (d == 1) lab1 = lab; else lab3 = lab;
    t_first = cyc;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check($sformatf("u%0d_op%0d_during_frame", d, i - 1), 32'(get_op(d, i - 1)), 32'(nb[i - 1]));
        check($sformatf("u%0d_rule_during_frame", d), 32'(get_rule(d)), 32'(rl[0]));
      end
      drive(d, 1'b1, nb[i], rl[i]);
    end
    t_last = cyc;
    e.val = expv;
    e.cyc = t_last + s + 1;
    if (d == 1) q1.push_back(e); else q3.push_back(e);
    $display("u%0d frame %h %h %h %h %h %h rule=%0d lab_out=0x%0h first=%0d last=%0d",
             d, nb[0], nb[1], nb[2], nb[3], nb[4], nb[5], rl[0], lab, t_first, t_last);
    @(negedge clk);
    drive(d, 1'b0, 4'd0, 3'd0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("u%0d_op%0d_after_frame", d, i), 32'(get_op(d, i)), 32'(nb[i]));
    end
    check($sformatf("u%0d_rule_after_frame", d), 32'(get_rule(d)), 32'(rl[0]));
    check($sformatf("u%0d_ready_low_in_settle", d), 32'(get_rdy(d)), 32'd0);
  endtask

  task automatic drain(input int d);
    int guard;
    guard = 0;
    while (((d == 1) ? q1.size() : q3.size()) != 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("u%0d_results_drained", d), 32'((d == 1) ? q1.size() : q3.size()), 32'd0);
  endtask

  task automatic set_frame(input logic [23:0] nibs, input logic [2:0] r0, input logic [2:0] rrest);
    for (int i = 0; i < 6; i++) begin
      nb[i] = nibs[23 - 4 * i -: 4];
      rl[i] = (i == 0) ? r0 : rrest;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int tf, tl, tf2, tl2, g;
    rst_n1 = 1'b0; rst_n3 = 1'b0;
    iv1 = 1'b0; id1 = 4'd0; ir1 = 3'd0; lab1 = 10'd0;
    iv3 = 1'b0; id3 = 4'd0; ir3 = 3'd0; lab3 = 10'd0;
    #1;
    for (int i = 0; i < 6; i++) check($sformatf("reset_op%0d", i), 32'(op1[i]), 32'd0);
    check("reset_rule", 32'(rule1), 32'd0);
    check("reset_ready", 32'(rdy1), 32'd1);
    check("reset_out_valid", 32'(ov1), 32'd0);
    check("reset_out", 32'(out1), 32'd0);
    check("reset_err", 32'(err1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n1 = 1'b1; rst_n3 = 1'b1;

    // Basic frame, -37 -> 10'h3DB
    set_frame(24'h123456, 3'd2, 3'd2);
    send_frame(1, -10'sd37, 10'h3DB, tf, tl);
    drain(1);

    // Rule sampled only with the first nibble
    set_frame(24'h7A3C09, 3'd5, 3'd7);
    send_frame(1, 10'h155, 10'h155, tf, tl);
    drain(1);

    // Abort after three nibbles
    @(negedge clk);
    drive(1, 1'b1, 4'hA, 3'd4);
    @(negedge clk);
    drive(1, 1'b1, 4'hB, 3'd1);
    @(negedge clk);
    drive(1, 1'b1, 4'hC, 3'd1);
    @(negedge clk);
    drive(1, 1'b0, 4'd0, 3'd0);
    check("abort_op2_before_gap", 32'(op1[2]), 32'hC);
    check("abort_rule_before_gap", 32'(rule1), 32'd4);
    check("abort_err_low_in_gap", 32'(err1), 32'd0);
    @(negedge clk);
    check("abort_err_pulse", 32'(err1), 32'd1);
    for (int i = 0; i < 6; i++) check($sformatf("abort_op%0d_cleared", i), 32'(op1[i]), 32'd0);
    check("abort_rule_cleared", 32'(rule1), 32'd0);
    check("abort_ready", 32'(rdy1), 32'd1);
    $display("u1 abort err=%0d cycle=%0d", err1, cyc);
    @(negedge clk);
    check("abort_err_single_cycle", 32'(err1), 32'd0);
    set_frame(24'h0F1E2D, 3'd3, 3'd3);
    send_frame(1, 10'h0AA, 10'h0AA, tf, tl);
    drain(1);

    // Boundary operands
    set_frame(24'hFFFFFF, 3'd7, 3'd7);
    send_frame(1, 10'h3FF, 10'h3FF, tf, tl);
    drain(1);
    set_frame(24'h000000, 3'd0, 3'd0);
    send_frame(1, 10'h000, 10'h000, tf, tl);
    drain(1);

    // Back-to-back on SETTLE_CYCLES=3 with ignored pulses in between
    set_frame(24'h987654, 3'd1, 3'd1);
    send_frame(3, 10'h1FF, 10'h1FF, tf, tl);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(3, 1'b1, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      check("b2b_ready_low", 32'(rdy3), 32'd0);
      for (int i = 0; i < 6; i++) check($sformatf("b2b_op%0d_held", i), 32'(op3[i]), 32'(nb[i]));
      check("b2b_rule_held", 32'(rule3), 32'd1);
    end
    set_frame(24'h3CE0F1, 3'd6, 3'd2);
    send_frame(3, 10'h200, 10'h200, tf2, tl2);
    check("b2b_frame2_start_cycle", 32'(tf2), 32'(tl + 5));
    drain(3);

    // Async reset mid-settle
    set_frame(24'h55AA55, 3'd5, 3'd5);
    send_frame(3, 10'h0F0, 10'h0F0, tf, tl);
    #1;
    rst_n3 = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) check($sformatf("rst_op%0d", i), 32'(op3[i]), 32'd0);
    check("rst_rule", 32'(rule3), 32'd0);
    check("rst_out", 32'(out3), 32'd0);
    check("rst_out_valid", 32'(ov3), 32'd0);
    check("rst_ready", 32'(rdy3), 32'd1);
    $display("u3 reset asserted mid-settle cycle=%0d", cyc);
    q3.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n3 = 1'b1;
    g = 0;
    while (g < 8) begin
      @(negedge clk);
      g++;
    end
    check("rst_ready_after_release", 32'(rdy3), 32'd1);
    set_frame(24'h13579B, 3'd4, 3'd0);
    send_frame(3, 10'h123, 10'h123, tf, tl);
    drain(3);

    @(negedge clk);
    check("u1_err_count", 32'(err_cnt1), 32'd1);
    check("u3_err_count", 32'(err_cnt3), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
